// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pattern encodings, colour-bar table and FSM states
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_COUNT = 2'd3
    } pattern_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - combinational pixel generator for the test patterns
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int CHK_SHIFT = 3
) (
    input  pattern_t        mode,
    input  logic [XW-1:0]   x,
    input  logic [YW-1:0]   y,
    input  logic [2:0]      bar,
    input  logic [7:0]      frame_lsb,
    output logic [23:0]     pixel
);

    always_comb begin
        pixel = 24'h000000;
        case (mode)
            PAT_BARS:  pixel = bar_color(bar);
            PAT_GRAD:  pixel = {3{8'(x)}};
            PAT_CHECK: pixel = ((((32'(x) >> CHK_SHIFT) ^ (32'(y) >> CHK_SHIFT)) & 32'd1) != 32'd0)
                               ? 24'hFFFFFF : 24'h000000;
            PAT_COUNT: pixel = {frame_lsb, 8'(y), 8'(x)};
            default:   pixel = 24'h000000;
        endcase
    end

endmodule

// File: rtl/video_pattern_streamer.sv
// rtl/video_pattern_streamer.sv - AXI4-Stream test-pattern frame source (option: VIDEO_STREAMER_FRAME_SUM_EN)
module video_pattern_streamer
    import video_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 16,
    parameter int CHK_SHIFT  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                frame_done,
    output logic [15:0]         frame_cnt
`ifdef VIDEO_STREAMER_FRAME_SUM_EN
    ,
    output logic [31:0]         frame_sum
`endif
);

    localparam int XW       = $clog2(H_RES);
    localparam int YW       = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int BAR_PX   = H_RES / 8;
    localparam int BW       = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t          state;
    pattern_t        mode_r;
    logic [XW-1:0]   x, nx, gen_x;
    logic [YW-1:0]   y, ny, gen_y;
    logic [2:0]      bar, nbar, gen_bar;
    logic [BW-1:0]   bar_px, nbar_px;
    logic [GW-1:0]   gap_cnt;
    pattern_t        gen_mode;
    logic [23:0]     pixel;
    logic            xfer, line_end, frame_end;

    // x/y/bar hold the coordinates of the beat currently presented; nx/ny/nbar are the following beat
    always_comb begin
        xfer      = m_axis_tvalid && m_axis_tready;
        line_end  = (x == XW'(H_RES - 1));
        frame_end = line_end && (y == YW'(V_RES - 1));
        nx        = line_end ? '0 : x + 1'b1;
        ny        = line_end ? y + 1'b1 : y;
        nbar      = bar;
        nbar_px   = bar_px + 1'b1;
        if (line_end) begin
            nbar    = 3'd0;
            nbar_px = '0;
        end else if (bar_px == BW'(BAR_PX - 1)) begin
            nbar    = bar + 3'd1;
            nbar_px = '0;
        end
        if (state == IDLE) begin
            gen_mode = pattern_t'(mode);
            gen_x    = '0;
            gen_y    = '0;
            gen_bar  = 3'd0;
        end else begin
            gen_mode = mode_r;
            gen_x    = nx;
            gen_y    = ny;
            gen_bar  = nbar;
        end
    end

    video_pattern_gen #(
        .XW        (XW),
        .YW        (YW),
        .CHK_SHIFT (CHK_SHIFT)
    ) u_gen (
        .mode      (gen_mode),
        .x         (gen_x),
        .y         (gen_y),
        .bar       (gen_bar),
        .frame_lsb (frame_cnt[7:0]),
        .pixel     (pixel)
    );

    assign m_axis_tkeep = {(DATA_W/8){m_axis_tvalid}};

`ifdef VIDEO_STREAMER_FRAME_SUM_EN
    logic [31:0] acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mode_r        <= PAT_BARS;
            x             <= '0;
            y             <= '0;
            bar           <= 3'd0;
            bar_px        <= '0;
            gap_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= 16'd0;
`ifdef VIDEO_STREAMER_FRAME_SUM_EN
            acc           <= 32'd0;
            frame_sum     <= 32'd0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state         <= ACTIVE;
                        mode_r        <= pattern_t'(mode);
                        x             <= '0;
                        y             <= '0;
                        bar           <= 3'd0;
                        bar_px        <= '0;
                        m_axis_tdata  <= DATA_W'(pixel);
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b1;
                        m_axis_tvalid <= 1'b1;
`ifdef VIDEO_STREAMER_FRAME_SUM_EN
                        acc           <= 32'd0;
`endif
                    end
                end
                ACTIVE: begin
                    if (xfer) begin
`ifdef VIDEO_STREAMER_FRAME_SUM_EN
                        acc <= acc + 32'(m_axis_tdata[23:0]);
`endif
                        if (frame_end) begin
                            state         <= GAP;
                            gap_cnt       <= '0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tuser  <= 1'b0;
                            frame_done    <= 1'b1;
                            frame_cnt     <= frame_cnt + 16'd1;
`ifdef VIDEO_STREAMER_FRAME_SUM_EN
                            frame_sum     <= acc + 32'(m_axis_tdata[23:0]);
`endif
                        end else begin
                            x            <= nx;
                            y            <= ny;
                            bar          <= nbar;
                            bar_px       <= nbar_px;
                            m_axis_tdata <= DATA_W'(pixel);
                            m_axis_tlast <= (nx == XW'(H_RES - 1));
                            m_axis_tuser <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_LAST)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_pattern_streamer.sv
// tb/tb_video_pattern_streamer.sv - randomized bench against a frame-level reference model
module tb_video_pattern_streamer;

    localparam int H_RES      = 16;
    localparam int V_RES      = 4;
    localparam int DATA_W     = 32;
    localparam int GAP_CYCLES = 2;
    localparam int CHK_SHIFT  = 3;
    localparam int BEATS      = H_RES * V_RES;
    localparam int GAP_EDGES  = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [1:0]          mode;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tuser;
    logic                tvalid;
    logic                tready;
    logic                frame_done;
    logic [15:0]         frame_cnt;
`ifdef VIDEO_STREAMER_FRAME_SUM_EN
    logic [31:0]         frame_sum;
`endif

    always #5 clk = ~clk;

    video_pattern_streamer #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .DATA_W     (DATA_W),
        .GAP_CYCLES (GAP_CYCLES),
        .CHK_SHIFT  (CHK_SHIFT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .mode          (mode),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt)
`ifdef VIDEO_STREAMER_FRAME_SUM_EN
        ,
        .frame_sum     (frame_sum)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] ref_pixel(input int md, input int px, input int py, input int fnum);
        logic [31:0] xv, yv, fv;
        xv = px;
        yv = py;
        fv = fnum;
        case (md)
            0:       return bars[px / (H_RES / 8)];
            1:       return {xv[7:0], xv[7:0], xv[7:0]};
            2:       return (((px >> CHK_SHIFT) ^ (py >> CHK_SHIFT)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
            default: return {fv[7:0], yv[7:0], xv[7:0]};
        endcase
    endfunction

    // Frame-level model: a frame is BEATS accepted beats; after it the source ignores enable for a gap
    bit          in_frame = 0;
    int          k = 0;
    int          gap_left = 0;
    int          fmode = 0;
    int          fnum = 0;
    logic [15:0] fcnt = 16'd0;
    bit          exp_done = 0;
    logic [31:0] run_sum = 0;
    logic [31:0] exp_sum = 0;
    int          frames_seen = 0;

    task automatic step();
        logic [23:0] p;
        @(posedge clk);
        #1;
        exp_done = 0;
        if (rst) begin
            in_frame = 0;
            gap_left = 0;
            fcnt     = 16'd0;
            exp_sum  = 0;
            run_sum  = 0;
        end else if (in_frame) begin
            if (tready) begin
                run_sum += 32'(ref_pixel(fmode, k % H_RES, k / H_RES, fnum));
                k++;
                if (k == BEATS) begin
                    in_frame = 0;
                    exp_done = 1;
                    fcnt     = fcnt + 16'd1;
                    exp_sum  = run_sum;
                    gap_left = GAP_EDGES;
                    frames_seen++;
                end
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end else if (enable) begin
            in_frame = 1;
            k        = 0;
            fmode    = mode;
            fnum     = fcnt;
            run_sum  = 0;
        end

        check_eq("tvalid", 32'(tvalid), 32'(in_frame));
        check_eq("tkeep", 32'(tkeep), in_frame ? 32'hF : 32'h0);
        check_eq("frame_done", 32'(frame_done), 32'(exp_done));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(fcnt));
        if (in_frame) begin
            p = ref_pixel(fmode, k % H_RES, k / H_RES, fnum);
            check_eq("tdata", tdata, 32'(p));
            check_eq("tlast", 32'(tlast), 32'((k % H_RES) == H_RES - 1));
            check_eq("tuser", 32'(tuser), 32'(k == 0));
        end else if (rst) begin
            check_eq("rst_tdata", tdata, 32'h0);
            check_eq("rst_tlast", 32'(tlast), 32'h0);
            check_eq("rst_tuser", 32'(tuser), 32'h0);
        end
`ifdef VIDEO_STREAMER_FRAME_SUM_EN
        check_eq("frame_sum", frame_sum, exp_sum);
`endif
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        mode   = 2'd0;
        tready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 599) == 0);
            enable = ($urandom_range(0, 7) != 0);
            mode   = 2'($urandom_range(0, 3));
            if ((i % 400) < 150) tready = 1'b1;
            else                 tready = ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 1'b0;
        check_eq("frames_completed_nonzero", 32'(frames_seen > 5), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
